// File: rtl/mult_seq_32_if.sv
// mult_seq_32_if: request/result bundle for the sequential 32x32 multiplier.
// Signals: START, SIGNED, A, B (requester -> multiplier); P, BUSY, DONE (back).
interface mult_seq_32_if;
    logic        START;
    logic        SIGNED;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] P;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START, SIGNED, A, B,
        input  P, BUSY, DONE
    );

    modport slave (
        input  START, SIGNED, A, B,
        output P, BUSY, DONE
    );
endinterface

// File: rtl/mult_seq_32.sv
// mult_seq_32: radix-2 shift-add 32x32->64 multiplier, 33-cycle latency.
// Ports: CLK, RST (sync, active-high), bus (mult_seq_32_if.slave).
// Optional signed support is enabled by defining MULT_SEQ_SIGNED_EN.

module RC_ADD_SUB_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SnA,
    output logic [31:0] S,
    output logic        CO
);
    logic [32:0] c;
    logic [31:0] bx;

    // SnA=1 computes A - B as A + ~B + 1
    always_comb begin
        bx   = B ^ {32{SnA}};
        c    = '0;
        S    = '0;
        c[0] = SnA;
        for (int i = 0; i < 32; i++) begin
            S[i]   = A[i] ^ bx[i] ^ c[i];
            c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
        end
        CO = c[32];
    end
endmodule

`ifdef MULT_SEQ_SIGNED_EN
module RC_ADD_SUB_64 (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        SnA,
    output logic [63:0] S,
    output logic        CO
);
    logic [64:0] c;
    logic [63:0] bx;

    always_comb begin
        bx   = B ^ {64{SnA}};
        c    = '0;
        S    = '0;
        c[0] = SnA;
        for (int i = 0; i < 64; i++) begin
            S[i]   = A[i] ^ bx[i] ^ c[i];
            c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
        end
        CO = c[64];
    end
endmodule
`endif

module mult_seq_32 (
    input  logic          CLK,
    input  logic          RST,
    mult_seq_32_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic [63:0] p_q;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] fix_prod;
    logic [31:0] add_s;
    logic        add_co;
    logic        accept;

    assign accept = (state == S_IDLE) && bus.START;

    // Upper accumulator half plus multiplicand; carry becomes bit 63
    // after the right shift.
    RC_ADD_SUB_32 u_add (
        .A   (acc[63:32]),
        .B   (mcand),
        .SnA (1'b0),
        .S   (add_s),
        .CO  (add_co)
    );

`ifdef MULT_SEQ_SIGNED_EN
    logic        neg;
    logic        neg_in;
    logic [63:0] neg_s;
    logic        unused_neg_co;

    // -0x80000000 wraps to 0x80000000, which is 2^31 read unsigned
    assign mag_a  = (bus.SIGNED && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    assign mag_b  = (bus.SIGNED && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    assign neg_in = bus.SIGNED & (bus.A[31] ^ bus.B[31]);

    RC_ADD_SUB_64 u_neg (
        .A   (64'd0),
        .B   (acc),
        .SnA (1'b1),
        .S   (neg_s),
        .CO  (unused_neg_co)
    );

    assign fix_prod = neg ? neg_s : acc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= neg_in;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = bus.SIGNED;
    assign mag_a         = bus.A;
    assign mag_b         = bus.B;
    assign fix_prod      = acc;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (bus.START) state_nx = S_CALC;
            S_CALC: if (cnt == 6'd31) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p_q    <= '0;
        end else begin
            if (accept) begin
                acc    <= '0;
                cnt    <= '0;
                mcand  <= mag_a;
                mplier <= mag_b;
            end
            if (state == S_CALC) begin
                if (mplier[0]) begin
                    acc <= {add_co, add_s, acc[31:1]};
                end else begin
                    acc <= {1'b0, acc[63:1]};
                end
                mplier <= {1'b0, mplier[31:1]};
                cnt    <= cnt + 6'd1;
            end
            if (state == S_FIX) begin
                p_q <= fix_prod;
            end
        end
    end

    assign bus.P    = p_q;
    assign bus.BUSY = (state == S_CALC) || (state == S_FIX);
    assign bus.DONE = (state == S_DONE);
endmodule

// File: tb/tb_mult_seq_32.sv
// tb_mult_seq_32: randomized self-checking bench for mult_seq_32.
// Drives requests through mult_seq_32_if and compares against an arithmetic model.
module tb_mult_seq_32;
    logic CLK;
    logic RST;
    int   n_vec;
    int   n_bad;

    mult_seq_32_if bus ();

    mult_seq_32 dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
`ifdef MULT_SEQ_SIGNED_EN
        if (sgn) return sa * sb;
`endif
        if (sgn && (sa == sb) && 1'b0) return '0;
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Called at a sample point (#1 after an edge) with the DUT idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input bit noise);
        logic [63:0] exp;
        int dk;
        int nd;
        exp = model(a, b, sgn);
        bus.A = a;
        bus.B = b;
        bus.SIGNED = sgn;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        check("busy_t0", 64'(bus.BUSY), 64'd1);
        dk = 0;
        nd = 0;
        for (int k = 1; k <= 37; k++) begin
            if (noise && k <= 34) begin
                bus.START  = 1'($urandom);
                bus.A      = $urandom;
                bus.B      = $urandom;
                bus.SIGNED = 1'($urandom);
            end else begin
                bus.START = 1'b0;
            end
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                nd++;
                if (dk == 0) begin
                    dk = k;
                    check("product", bus.P, exp);
                end
            end
            if (k == 32) check("busy_t32", 64'(bus.BUSY), 64'd1);
            if (k == 33) check("busy_t33", 64'(bus.BUSY), 64'd0);
        end
        check("latency", 64'(dk), 64'd33);
        check("done_count", 64'(nd), 64'd1);
        check("p_hold", bus.P, exp);
    endtask

    initial begin
        int c0;
        int c1;
        int nd;
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec = 0;
        n_bad = 0;
        bus.START = 1'b0;
        bus.SIGNED = 1'b0;
        bus.A = '0;
        bus.B = '0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_p", bus.P, 64'd0);
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        check("rst_done", 64'(bus.DONE), 64'd0);
        RST = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        run_op(32'h80000000, 32'd7, 1'b1, 1'b0);
        run_op(32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        run_op(32'd12345, 32'd0, 1'b1, 1'b0);
        run_op(32'd2, 32'd2, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'($urandom), bit'(i[0]));
        end

        // Reset in the middle of a calculation
        bus.A = 32'd6;
        bus.B = 32'd7;
        bus.SIGNED = 1'b0;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_p", bus.P, 64'd0);
        check("abort_busy", 64'(bus.BUSY), 64'd0);
        check("abort_done", 64'(bus.DONE), 64'd0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        run_op(32'd6, 32'd7, 1'b0, 1'b0);

        // Back-to-back with START held high
        bus.A = 32'd2;
        bus.B = 32'd3;
        bus.SIGNED = 1'b0;
        bus.START = 1'b1;
        c0 = -1;
        c1 = -1;
        for (int k = 1; k <= 90 && c1 < 0; k++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                if (c0 < 0) begin
                    c0 = k;
                    check("b2b_first", bus.P, 64'd6);
                    bus.A = 32'd4;
                    bus.B = 32'd5;
                end else begin
                    c1 = k;
                    check("b2b_second", bus.P, 64'd20);
                    bus.START = 1'b0;
                end
            end
        end
        bus.START = 1'b0;
        check("b2b_gap", 64'(c1 - c0), 64'd35);
        repeat (40) @(posedge CLK);
        #1;
        check("b2b_idle", 64'(bus.BUSY), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
